// File: rtl/relprime_scheduler.sv
// rtl/relprime_scheduler.sv - round-robin front end sharing one relprime processor
//
// Purpose: arbitrates NUM_REQ requesters onto a single relprime processor, launches
// each job with a START_CYCLES-long start pulse, waits for the result (with a
// watchdog) and returns it to the granted requester.
//
// Ports:
//   CLK, reset            clock, synchronous active-high reset
//   req_valid/req_data    per-requester operand requests (data packed DATA_W per lane)
//   req_ready             one-hot accept pulse, combinational in IDLE
//   rsp_valid             one-hot result pulse toward the granted requester
//   rsp_data/rsp_timeout  result word and abort flag, held until the next DONE
//   busy, grant_id        scheduler occupied / current or last granted index
//   proc_*                processor side: operand, constants, start, result, done
module relprime_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 16,
    parameter int START_CYCLES = 4,
    parameter int TIMEOUT      = 65535,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1,
    localparam int WD_W = $clog2(TIMEOUT)
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic [DATA_W-1:0]       proc_register_value,
    output logic [DATA_W-1:0]       proc_decimal_two,
    output logic [DATA_W-1:0]       proc_decimal_one,
    output logic                    proc_start,
    input  logic [DATA_W-1:0]       proc_out,
    input  logic                    proc_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [SC_W-1:0] start_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            done_armed;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   cand;
    logic            done_accept;

    assign proc_decimal_two = DATA_W'(2);
    assign proc_decimal_one = DATA_W'(1);

    // Rotating search starting at rr_ptr; the first valid index found wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Gated by reset so no accept is signalled while the FSM is being cleared.
    assign req_ready = (state == S_IDLE && gnt_found && !reset)
                     ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state == S_DONE) ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy      = (state != S_IDLE);

    // A done level left over from the previous job is ignored until the
    // processor has been seen with done low during this job.
    assign done_accept = proc_done && done_armed;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state               <= S_IDLE;
            rr_ptr              <= '0;
            start_cnt           <= '0;
            wd_cnt              <= '0;
            done_armed          <= 1'b0;
            rsp_data            <= '0;
            rsp_timeout         <= 1'b0;
            grant_id            <= '0;
            proc_register_value <= '0;
            proc_start          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        proc_register_value <= req_data[gnt_idx*DATA_W +: DATA_W];
                        grant_id            <= gnt_idx;
                        rr_ptr              <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                        proc_start          <= 1'b1;
                        start_cnt           <= '0;
                        done_armed          <= 1'b0;
                        state               <= S_START;
                    end
                end
                S_START: begin
                    if (!proc_done) begin
                        done_armed <= 1'b1;
                    end
                    if (start_cnt == SC_W'(START_CYCLES-1)) begin
                        proc_start <= 1'b0;
                        wd_cnt     <= '0;
                        state      <= S_WAIT;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!proc_done) begin
                        done_armed <= 1'b1;
                    end
                    if (done_accept) begin
                        rsp_data    <= proc_out;
                        rsp_timeout <= 1'b0;
                        state       <= S_DONE;
                    end else if (wd_cnt == WD_W'(TIMEOUT-1)) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relprime_scheduler.sv
// tb/tb_relprime_scheduler.sv - self-checking bench for relprime_scheduler
module tb_relprime_scheduler;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] proc_register_value;
    logic [15:0] proc_decimal_two;
    logic [15:0] proc_decimal_one;
    logic        proc_start;
    logic [15:0] proc_out = '0;
    logic        proc_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    relprime_scheduler #(
        .NUM_REQ(4), .DATA_W(16), .START_CYCLES(4), .TIMEOUT(100)
    ) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .grant_id(grant_id),
        .proc_register_value(proc_register_value),
        .proc_decimal_two(proc_decimal_two), .proc_decimal_one(proc_decimal_one),
        .proc_start(proc_start), .proc_out(proc_out), .proc_done(proc_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] relprime(input logic [15:0] n);
        int a, b, t;
        for (int m = 2; m < 65535; m++) begin
            a = m;
            b = int'(n);
            while (b != 0) begin
                t = a % b;
                a = b;
                b = t;
            end
            if (a == 1) return 16'(m);
        end
        return 16'd0;
    endfunction

    // Processor model. mode 0: one-cycle done 20 cycles after start falls.
    // mode 1: never done. mode 2: done high through START and two WAIT cycles,
    // low three cycles, then high with 13. mode 3: done stuck high.
    int mode = 0;
    int mcnt = 0;
    bit mrun = 1'b0;
    always @(negedge CLK) begin
        if (proc_start) begin
            mcnt = 0;
            mrun = 1'b1;
        end else if (mrun) begin
            mcnt++;
        end
        case (mode)
            0: begin
                proc_done = mrun && !proc_start && (mcnt == 20);
                proc_out  = proc_done ? relprime(proc_register_value) : 16'hdead;
            end
            1: begin
                proc_done = 1'b0;
                proc_out  = 16'hbeef;
            end
            2: begin
                proc_done = proc_start || (mrun && (mcnt <= 2 || mcnt >= 6));
                proc_out  = (!proc_start && mcnt >= 6) ? 16'd13 : 16'd99;
            end
            default: begin
                proc_done = 1'b1;
                proc_out  = 16'd77;
            end
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] data;
        int          mode;
        int          grant;
        logic [15:0] result;
        logic        tmo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic run_job(input int r);
        vec_t v;
        int   k;
        int   n;
        int   lat;
        v = vecs[r];
        req_data  = v.data;
        req_valid = v.mask;
        mode      = v.mode;
        #1;
        k = 0;
        while (req_ready == 0 && k < 50) begin
            @(negedge CLK); #1;
            k++;
        end
        if (req_ready == 0) begin
            check($sformatf("row%0d_grant_wait", r), 64'd0, 64'd1);
            req_valid = '0;
            return;
        end
        check($sformatf("row%0d_req_ready", r), req_ready, 64'd1 << v.grant);
        check($sformatf("row%0d_busy_at_grant", r), busy, 0);
        @(negedge CLK);
        req_valid = '0;
        check($sformatf("row%0d_operand", r), proc_register_value, v.data[v.grant*16 +: 16]);
        check($sformatf("row%0d_grant_id", r), grant_id, v.grant);
        check($sformatf("row%0d_busy", r), busy, 1);
        n = 0;
        while (proc_start && n < 20) begin
            n++;
            @(negedge CLK);
        end
        check($sformatf("row%0d_start_len", r), n, 4);
        lat = 1;
        while (rsp_valid == 0 && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        check($sformatf("row%0d_rsp_valid", r), rsp_valid, 64'd1 << v.grant);
        check($sformatf("row%0d_rsp_data", r), rsp_data, v.result);
        check($sformatf("row%0d_rsp_timeout", r), rsp_timeout, v.tmo);
        check($sformatf("row%0d_latency", r), lat, v.lat);
        @(negedge CLK);
        check($sformatf("row%0d_rsp_pulse", r), rsp_valid, 0);
        check($sformatf("row%0d_rsp_hold", r), rsp_data, v.result);
        check($sformatf("row%0d_idle", r), busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_operand"}, proc_register_value, 0);
        check({tag, "_proc_start"}, proc_start, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    localparam logic [63:0] D2 = {16'd4590, 16'd25534, 16'd36432, 16'd4620};

    initial begin
        int k;
        int grants;
        bit prev_rsp;
        bit exp_idle;

        vecs[0] = '{4'b1111, D2, 0, 0, 16'd13, 1'b0, 21};
        vecs[1] = '{4'b1110, D2, 0, 1, 16'd5,  1'b0, 21};
        vecs[2] = '{4'b1100, D2, 0, 2, 16'd3,  1'b0, 21};
        vecs[3] = '{4'b1000, D2, 0, 3, 16'd7,  1'b0, 21};
        vecs[4] = '{4'b1010, D2, 0, 1, 16'd5,  1'b0, 21};
        vecs[5] = '{4'b0001, {48'd0, 16'd5040}, 0, 0, 16'd11, 1'b0, 21};
        vecs[6] = '{4'b0100, {16'd0, 16'd1234, 32'd0}, 1, 2, 16'd0, 1'b1, 101};
        vecs[7] = '{4'b0001, {48'd0, 16'd5040}, 0, 0, 16'd11, 1'b0, 21};
        vecs[8] = '{4'b0010, {32'd0, 16'd4620, 16'd0}, 2, 1, 16'd13, 1'b0, 7};
        vecs[9] = '{4'b1000, {16'd999, 48'd0}, 3, 3, 16'd0, 1'b1, 101};

        // Reset state and constant outputs
        do_reset();
        #1;
        check_reset_outputs("rst");
        check("const_two", proc_decimal_two, 2);
        check("const_one", proc_decimal_one, 1);
        @(negedge CLK);

        // Round-robin sequence, single job, timeout, stale done, stuck done
        for (int r = 0; r < 10; r++) begin
            run_job(r);
        end

        // Reset mid-WAIT on the second job
        mode = 0;
        do_reset();
        run_job(0);
        req_data  = D2;
        req_valid = 4'b1110;
        #1;
        check("mid_grant1", req_ready, 4'b0010);
        @(negedge CLK);
        req_valid = '0;
        k = 0;
        while (proc_start && k < 20) begin
            @(negedge CLK);
            k++;
        end
        repeat (5) @(negedge CLK);
        check("mid_in_wait", busy, 1);
        reset     = 1'b1;
        req_valid = 4'b0101;
        @(negedge CLK); #1;
        check_reset_outputs("midrst");
        @(negedge CLK); #1;
        check("midrst2_rsp_valid", rsp_valid, 0);
        check("midrst2_start", proc_start, 0);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        @(negedge CLK);
        req_valid = '0;
        check("post_rst_grant_id", grant_id, 0);
        check("post_rst_operand", proc_register_value, 16'd4620);
        k = 0;
        while (rsp_valid == 0 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check("post_rst_rsp_valid", rsp_valid, 4'b0001);
        check("post_rst_rsp_data", rsp_data, 16'd13);

        // Back-to-back grants with req0 held valid
        do_reset();
        mode      = 0;
        req_data  = {48'd0, 16'd5040};
        req_valid = 4'b0001;
        grants    = 0;
        prev_rsp  = 1'b1;
        for (int c = 0; c < 86; c++) begin
            #1;
            exp_idle = prev_rsp;
            check($sformatf("b2b_busy_c%0d", c), busy, !exp_idle);
            check($sformatf("b2b_ready_c%0d", c), req_ready, exp_idle ? 4'b0001 : 4'b0000);
            if (req_ready != 0) grants++;
            if (rsp_valid != 0) begin
                check($sformatf("b2b_rsp_c%0d", c), rsp_data, 16'd11);
            end
            prev_rsp = (rsp_valid != 0);
            @(negedge CLK);
        end
        check("b2b_grant_count", grants, 4);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
